// File: rtl/mult_seq_ctrl_pkg.sv
// Shared state encoding and width constants for the sequential signed multiplier.
package mult_seq_ctrl_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int PROD_WIDTH = 2 * DEF_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        ITER   = 3'd2,
        FIX    = 3'd3,
        DONE_S = 3'd4
    } state_t;

endpackage

// File: rtl/mult_iter_dp.sv
// Shift-add accumulator: one conditional add of the multiplicand plus right shift per cycle.
// Single-cycle update, no flow control; the sequencer drives load/add/shift directly.
module mult_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [2*WIDTH-1:0]   load_val_i,
    input  logic                 add_en_i,
    input  logic                 shift_en_i,
    input  logic [WIDTH-1:0]     mcand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum_d;

    assign addend = add_en_i ? mcand_i : {WIDTH{1'b0}};
    // Carry out of the upper-half add becomes the new MSB after the shift.
    assign sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (shift_en_i) begin
            acc_d = {sum_d, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential signed WIDTH x WIDTH multiplier; DONE pulses WIDTH+3 cycles after START (2 with MULT_ZERO_BYPASS_EN on zero operands).
// One request at a time: START is ignored unless IDLE, HI/LO hold until the next result.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] mag_a_q;
    logic             sign_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_fixed;
    logic             dp_load;
    logic [PW-1:0]    dp_load_val;
    logic             dp_add;
    logic             dp_shift;

    // |-2^(W-1)| wraps back to 2^(W-1), which is still correct read as unsigned.
    assign mag_a_d   = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b_d   = b_q[WIDTH-1] ? -b_q : b_q;
    assign acc_fixed = sign_q ? -acc : acc;

    assign dp_load     = (state_q == PREP) || (state_q == FIX);
    assign dp_load_val = (state_q == PREP) ? {{WIDTH{1'b0}}, mag_b_d} : acc_fixed;
    assign dp_shift    = (state_q == ITER);
    assign dp_add      = (state_q == ITER) && acc[0];

    mult_iter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i      (CLK),
        .rst_n_i    (RESET),
        .load_i     (dp_load),
        .load_val_i (dp_load_val),
        .add_en_i   (dp_add),
        .shift_en_i (dp_shift),
        .mcand_i    (mag_a_q),
        .acc_o      (acc)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mag_a_q <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    mag_a_q <= mag_a_d;
                    sign_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    cnt_q   <= '0;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((a_q == '0) || (b_q == '0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= '0;
                        lo_q    <= '0;
                        state_q <= DONE_S;
                    end else begin
                        state_q <= ITER;
                    end
`else
                    state_q <= ITER;
`endif
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Results register on entry to DONE_S so HI/LO and DONE appear together.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= acc_fixed[PW-1:WIDTH];
                    lo_q    <= acc_fixed[WIDTH-1:0];
                    state_q <= DONE_S;
                end
                DONE_S: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
